fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Decoupled instruction-fetch front end that sits between the PC-select logic and decode.
- Issues sequential ibus reads from an internal fetch PC and buffers returned instructions in a DEPTH-entry circular queue.
- Decode pops entries with a valid/ready handshake, so an ibus miss or a decode stall no longer stalls the whole pipeline.
- Handles redirects (branch, trap, mret), including draining a stale in-flight ibus response, and reports misaligned fetch PCs as fault entries.

Parameters:
- DEPTH, 4, number of queue entries; must be >= 2; need not be a power of two.
- XLEN, 64, PC / address width.
- ILEN, 32, instruction width.
- RESET_PC, 64'h8000_0000, fetch PC after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch PC
- ireq_valid  out  1  ibus request valid
- ireq_addr  out  XLEN  ibus request address
- iresp_data_ok  in  1  ibus response valid (one cycle)
- iresp_data  in  ILEN  ibus response instruction
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts the head entry
- out_pc  out  XLEN  head entry PC
- out_instr  out  ILEN  head entry instruction
- out_fault  out  1  head entry is a misaligned-fetch fault
- count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset values:
  - state IDLE, queue empty, count 0.
  - ireq_valid 0, ireq_addr RESET_PC, fetch_pc RESET_PC.
  - out_valid 0; out_pc, out_instr and out_fault all 0.
- FSM states: IDLE, BUSY, DRAIN, FAULT. ireq_valid = (state==BUSY or DRAIN). ireq_addr comes from the registered req_addr.
- IDLE:
  - If count<DEPTH and fetch_pc[1:0]==0: req_addr<=fetch_pc, go to BUSY.
  - If count<DEPTH and fetch_pc[1:0]!=0: push {fetch_pc, 0, fault=1}, go to FAULT. No bus request is issued.
  - If count==DEPTH: stay in IDLE.
- BUSY:
  - ireq_valid and ireq_addr are held stable until iresp_data_ok. This holds even if the queue fills or a redirect arrives.
  - On data_ok: push {req_addr, iresp_data, 0}, fetch_pc<=req_addr+4, go to IDLE.
- DRAIN:
  - Request still held. On data_ok the response is discarded and the state goes to IDLE.
- FAULT: no fetching; leaves only on redirect (to IDLE).
- Latency and throughput:
  - data_ok in cycle t gives out_valid in cycle t+1.
  - The next request is issued no earlier than t+1, so peak rate is 1 instruction per 2 cycles plus bus latency.
- Reservation: a request starts only when count<DEPTH, and at most one request is outstanding. A push therefore never meets a full queue; no overflow check is needed, but assert it.
- Redirect has priority over push, pop and all FSM moves:
  - At the next edge the queue is empty (count 0) and fetch_pc<=redirect_pc.
  - BUSY goes to DRAIN. DRAIN stays DRAIN with the new PC. IDLE and FAULT go to IDLE.
  - Redirect coincident with data_ok: the response is discarded and the state goes to IDLE. This holds in both BUSY and DRAIN.
  - Redirect coincident with a pop: the pop is ignored because the entry is flushed.
- Pop: occurs when out_valid and out_ready are both high. Push and pop in the same cycle leave count unchanged.
- Queue pointers: head and tail increment and wrap from DEPTH-1 to 0. Full/empty is decided from count, not from pointer equality.
- Width rule: fetch_pc+4 wraps modulo 2^XLEN.
- Reset mid-operation: any in-flight request is abandoned with no drain, because the ibus is reset by the same reset.

Decomposition:
- Package fetch_pkg holds:
  - fq_entry_t, a struct {pc XLEN, instr ILEN, fault 1};
  - fq_state_t, an enum {IDLE, BUSY, DRAIN, FAULT};
  - localparam INSTR_BYTES = 4.
- Sub-module fq_fifo: circular buffer of fq_entry_t with push, pop, flush, count and head outputs, parametrised by DEPTH.
- The FSM and fetch-PC logic stay in fetch_queue.

Test Plan:
- Reset, out_ready=1, ibus data_ok 2 cycles after each request: addresses 0x80000000, 0x80000004, 0x80000008 in order; each out_pc matches its out_instr; count never exceeds 1.
- DEPTH=4, out_ready=0, ibus data_ok after 1 cycle: exactly 4 requests; count saturates at 4; ireq_valid stays 0 afterward. Then raise out_ready for one cycle: one new request issues.
- Redirect to 0x80001000 while BUSY on 0x80000010: ireq_addr holds 0x80000010 until data_ok; that response is not enqueued; the next request is to 0x80001000; count is 0 after the redirect.
- Redirect in the same cycle as data_ok and a pop with count=2: count becomes 0; the response is dropped; the next ireq_addr is the redirect PC.
- Redirect to 0x80000002: no ireq_valid; one entry appears with out_fault=1 and out_pc 0x80000002; fetching stays stopped until a redirect to 0x80000100 resumes it.
- Reset asserted while BUSY with count=3: next cycle ireq_valid=0, count=0, ireq_addr=0x80000000; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch queue: queue entry layout, FSM states and fetch granule.
package fetch_pkg;
   localparam int FQ_XLEN     = 64;
   localparam int FQ_ILEN     = 32;
   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [FQ_XLEN-1:0] pc;
      logic [FQ_ILEN-1:0] instr;
      logic               fault;
   } fq_entry_t;

   typedef enum logic [1:0] {IDLE, BUSY, DRAIN, FAULT} fq_state_t;
endpackage

// File: rtl/fq_fifo.sv
// Circular buffer of fetch entries; occupancy is tracked by count so DEPTH need not be a power of two.
module fq_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  fq_entry_t                  push_data,
   input  logic                       pop,
   input  logic                       flush,
   output fq_entry_t                  head,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   fq_entry_t         mem [DEPTH];
   logic [PW-1:0]     head_ptr_reg, tail_ptr_reg;
   logic [CW-1:0]     count_reg;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (push)
         mem[tail_ptr_reg] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head_ptr_reg <= '0;
         tail_ptr_reg <= '0;
         count_reg    <= '0;
      end else begin
         if (push)
            tail_ptr_reg <= ptr_inc(tail_ptr_reg);
         if (pop)
            head_ptr_reg <= ptr_inc(head_ptr_reg);
         count_reg <= count_reg + CW'(push) - CW'(pop);
      end
   end

   // A request is only launched with a free slot reserved, so a push can never see a full queue.
   always_ff @(posedge clk) begin
      if (!reset && !flush)
         assert (!(push && count_reg == CW'(DEPTH)));
   end

   assign head  = mem[head_ptr_reg];
   assign count = count_reg;
endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: sequential ibus reads into a small queue popped by decode.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter int              XLEN     = FQ_XLEN,
   parameter int              ILEN     = FQ_ILEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       redirect_valid,
   input  logic [XLEN-1:0]            redirect_pc,
   output logic                       ireq_valid,
   output logic [XLEN-1:0]            ireq_addr,
   input  logic                       iresp_data_ok,
   input  logic [ILEN-1:0]            iresp_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_pc,
   output logic [ILEN-1:0]            out_instr,
   output logic                       out_fault,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int CW = $clog2(DEPTH+1);

   fq_state_t       state_reg;
   logic [XLEN-1:0] fetch_pc_reg, req_addr_reg;
   fq_entry_t       head, push_data;
   logic            push, pop, has_room, fault_push;
   logic [CW-1:0]   count_int;

   assign has_room   = count_int < CW'(DEPTH);
   assign out_valid  = count_int != '0;
   assign pop        = out_valid && out_ready && !redirect_valid;
   assign fault_push = (state_reg == IDLE) && has_room && (fetch_pc_reg[1:0] != 2'b00);
   assign push       = !redirect_valid && (((state_reg == BUSY) && iresp_data_ok) || fault_push);

   always_comb begin
      push_data = '{pc: fetch_pc_reg, instr: '0, fault: 1'b1};
      if (state_reg == BUSY)
         push_data = '{pc: req_addr_reg, instr: iresp_data, fault: 1'b0};
   end

   fq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (head),
      .count     (count_int)
   );

   // Redirect wins over every other move; a request already on the bus must still be drained.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         fetch_pc_reg <= RESET_PC;
         req_addr_reg <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc_reg <= redirect_pc;
         if ((state_reg == BUSY || state_reg == DRAIN) && !iresp_data_ok)
            state_reg <= DRAIN;
         else
            state_reg <= IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (has_room) begin
                  if (fetch_pc_reg[1:0] == 2'b00) begin
                     req_addr_reg <= fetch_pc_reg;
                     state_reg    <= BUSY;
                  end else begin
                     state_reg <= FAULT;
                  end
               end
            end
            BUSY: begin
               if (iresp_data_ok) begin
                  fetch_pc_reg <= req_addr_reg + XLEN'(INSTR_BYTES);
                  state_reg    <= IDLE;
               end
            end
            DRAIN: begin
               if (iresp_data_ok)
                  state_reg <= IDLE;
            end
            default: ;
         endcase
      end
   end

   assign ireq_valid = (state_reg == BUSY) || (state_reg == DRAIN);
   assign ireq_addr  = req_addr_reg;
   assign out_pc     = out_valid ? head.pc : '0;
   assign out_instr  = out_valid ? head.instr : '0;
   assign out_fault  = out_valid ? head.fault : 1'b0;
   assign count      = count_int;
endmodule
